// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path.
// The fetch FSM state encoding lives here so the core control unit can decode
// the fetch unit's state with the same constants.
package instr_fetch_unit_pkg;

    localparam int IFU_ADDR_WIDTH  = 12;
    localparam int IFU_INSTR_WIDTH = 8;
    localparam int IFU_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } fetchState_t;

endpackage

// File: rtl/instr_fetch_unit_fetch_counter.sv
// fetch_counter: free-running count of accepted instructions.
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous reset, active-low (clears the count)
//   enable  in   count one event this cycle
//   count   out  current count, wraps to 0 after all-ones
module fetch_counter
    import instr_fetch_unit_pkg::*;
#(
    parameter int WIDTH = IFU_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    // Natural binary overflow gives the wrap to zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch sequencer feeding the decode stage of one core.
// Reads instruction memory at the current PC, hands the returned word to decode
// over a valid/ready handshake and drives the PC register's load/increment
// strobes, including branch redirects.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   start, halt              begin fetching (pulse) / stop after current instr (level)
//   pc_value                 current PC register output
//   pc_dataIn/pc_wrEn        PC load value (branch target) and load strobe
//   pc_incEn                 PC increment strobe
//   branch_en/branch_addr    redirect request and its target
//   mem_addr/mem_rdEn        instruction memory read port (data 1 cycle later)
//   mem_rdData               instruction memory read data
//   instr/instr_valid        word presented to decode
//   instr_ready              decode accepts instr this cycle
//   busy                     fetch FSM not idle
//   fetch_count              number of accepted instructions (wrapping)
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH  = IFU_ADDR_WIDTH,
    parameter int INSTR_WIDTH = IFU_INSTR_WIDTH,
    parameter int CNT_WIDTH   = IFU_CNT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic [ADDR_WIDTH-1:0]  pc_value,
    output logic [ADDR_WIDTH-1:0]  pc_dataIn,
    output logic                   pc_wrEn,
    output logic                   pc_incEn,
    input  logic                   branch_en,
    input  logic [ADDR_WIDTH-1:0]  branch_addr,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic                   mem_rdEn,
    input  logic [INSTR_WIDTH-1:0] mem_rdData,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   fetch_count
);

    fetchState_t            state_reg, state_next;
    logic [INSTR_WIDTH-1:0] instr_reg, instr_next;
    logic                   instrValid_reg, instrValid_next;
    logic                   acceptFire;
    logic                   branchHit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            instr_reg      <= '0;
            instrValid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            instr_reg      <= instr_next;
            instrValid_reg <= instrValid_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        instr_next      = instr_reg;
        instrValid_next = instrValid_reg;
        mem_rdEn        = 1'b0;
        pc_wrEn         = 1'b0;
        pc_incEn        = 1'b0;
        pc_dataIn       = '0;
        acceptFire      = 1'b0;
        branchHit       = branch_en && (state_reg != IDLE);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                mem_rdEn   = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                // Read data arrives this cycle; the PC steps past the word
                // just fetched so the next REQ addresses the following one.
                instr_next      = mem_rdData;
                instrValid_next = 1'b1;
                pc_incEn        = 1'b1;
                state_next      = PRESENT;
            end
            PRESENT: begin
                if (instr_ready) begin
                    acceptFire      = 1'b1;
                    instrValid_next = 1'b0;
                    state_next      = halt ? IDLE : REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A redirect overrides the normal flow: the read in flight (or the word
        // on display, if decode did not take it) is dropped and the increment
        // is cancelled so the load is the only PC update this cycle. An accept
        // in the same cycle still counts because acceptFire is left untouched.
        if (branchHit) begin
            pc_wrEn         = 1'b1;
            pc_dataIn       = branch_addr;
            pc_incEn        = 1'b0;
            instr_next      = instr_reg;
            instrValid_next = 1'b0;
            state_next      = halt ? IDLE : REQ;
        end
    end

    assign mem_addr    = pc_value;
    assign instr       = instr_reg;
    assign instr_valid = instrValid_reg;
    assign busy        = (state_reg != IDLE);

    fetch_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_fetchCounter (
        .clk    (clk),
        .rst    (rst),
        .enable (acceptFire),
        .count  (fetch_count)
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: models the PC register and a 1-cycle-latency
// instruction memory around the DUT. Expected instruction words are queued as
// fetches are launched and popped when decode accepts a word.
module tb_instr_fetch_unit;

    localparam int AW = 12;
    localparam int IW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          halt = 1'b0;
    logic          branch_en = 1'b0;
    logic          instr_ready = 1'b0;
    logic [AW-1:0] branch_addr = '0;
    logic [AW-1:0] pc_value, pc_dataIn, mem_addr;
    logic          pc_wrEn, pc_incEn, mem_rdEn, instr_valid, busy;
    logic [IW-1:0] mem_rdData = '0;
    logic [IW-1:0] instr;
    logic [CW-1:0] fetch_count;

    logic [IW-1:0] memArr [0:(1<<AW)-1];
    logic [AW-1:0] pcReg;
    logic [IW-1:0] expQ [$];
    logic [IW-1:0] expWord;

    int nVec = 0, nMis = 0;
    int incCnt = 0, rdCnt = 0, validCnt = 0, accCnt = 0;
    int inc0, rd0, v0, a0;
    logic done;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_WIDTH  (AW),
        .INSTR_WIDTH (IW),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .halt        (halt),
        .pc_value    (pc_value),
        .pc_dataIn   (pc_dataIn),
        .pc_wrEn     (pc_wrEn),
        .pc_incEn    (pc_incEn),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .mem_addr    (mem_addr),
        .mem_rdEn    (mem_rdEn),
        .mem_rdData  (mem_rdData),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .busy        (busy),
        .fetch_count (fetch_count)
    );

    // PC register: load has priority over increment.
    always @(posedge clk or negedge rst) begin
        if (!rst) pcReg <= '0;
        else if (pc_wrEn) pcReg <= pc_dataIn;
        else if (pc_incEn) pcReg <= pcReg + 12'd1;
    end
    assign pc_value = pcReg;

    // Instruction memory: data valid the cycle after the request.
    always @(posedge clk) begin
        mem_rdData <= mem_rdEn ? memArr[mem_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Outputs are examined just after the falling edge.
    task automatic neg();
        @(negedge clk);
        #1;
    endtask

    // Handshake monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            if (pc_incEn) incCnt++;
            if (mem_rdEn) rdCnt++;
            if (instr_valid) validCnt++;
            if (pc_wrEn && pc_incEn) chk("wr_inc_excl", 32'(pc_wrEn & pc_incEn), 32'd0);
            if (instr_valid && instr_ready) begin
                accCnt++;
                if (expQ.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    expWord = expQ.pop_front();
                    chk("sb_instr", 32'(instr), 32'(expWord));
                end
                $display("accept #%0d instr=%02h at t=%0t", accCnt, instr, $time);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) memArr[i] = IW'($urandom);
        memArr[0] = 8'hA5;

        // Reset values
        #2;
        chk("rst_instr", 32'(instr), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_rdEn", 32'(mem_rdEn), 32'd0);
        chk("rst_wrEn", 32'(pc_wrEn), 32'd0);
        chk("rst_incEn", 32'(pc_incEn), 32'd0);
        chk("rst_dataIn", 32'(pc_dataIn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Branch ignored in IDLE
        tick(); branch_en = 1'b1; branch_addr = 12'h055;
        neg();
        chk("idle_br_wrEn", 32'(pc_wrEn), 32'd0);
        chk("idle_br_busy", 32'(busy), 32'd0);
        tick(); branch_en = 1'b0;
        neg();
        chk("idle_br_pc", 32'(mem_addr), 32'd0);

        // 1: first fetch, 3-cycle latency, then halt on accept
        inc0 = incCnt;
        tick(); start = 1'b1; instr_ready = 1'b1; expQ.push_back(memArr[0]);
        neg(); chk("t1_idle_busy", 32'(busy), 32'd0);
        tick(); start = 1'b0;
        neg();
        chk("t1_req_rdEn", 32'(mem_rdEn), 32'd1);
        chk("t1_req_addr", 32'(mem_addr), 32'd0);
        chk("t1_req_busy", 32'(busy), 32'd1);
        tick();
        neg();
        chk("t1_wait_inc", 32'(pc_incEn), 32'd1);
        chk("t1_wait_valid", 32'(instr_valid), 32'd0);
        tick(); halt = 1'b1;
        neg();
        chk("t1_valid_c3", 32'(instr_valid), 32'd1);
        chk("t1_instr", 32'(instr), 32'hA5);
        tick(); halt = 1'b0;
        neg();
        chk("t1_halt_busy", 32'(busy), 32'd0);
        chk("t1_count", 32'(fetch_count), 32'd1);
        chk("t1_valid_clr", 32'(instr_valid), 32'd0);
        chk("t1_inc_pulses", 32'(incCnt - inc0), 32'd1);
        rd0 = rdCnt;
        repeat (4) tick();
        neg();
        chk("t1_idle_no_rd", 32'(rdCnt - rd0), 32'd0);

        // 2: decode stalls for 5 cycles
        tick(); start = 1'b1; instr_ready = 1'b0; expQ.push_back(memArr[1]);
        tick(); start = 1'b0;
        tick();
        tick();
        rd0 = rdCnt; inc0 = incCnt;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick();
            neg();
            chk("t2_hold_valid", 32'(instr_valid), 32'd1);
            chk("t2_hold_instr", 32'(instr), 32'(memArr[1]));
        end
        chk("t2_hold_no_rd", 32'(rdCnt - rd0), 32'd0);
        chk("t2_hold_no_inc", 32'(incCnt - inc0), 32'd0);
        tick(); instr_ready = 1'b1;
        tick();
        neg();
        chk("t2_req_rdEn", 32'(mem_rdEn), 32'd1);
        chk("t2_req_addr", 32'(mem_addr), 32'd2);
        chk("t2_req_valid", 32'(instr_valid), 32'd0);
        chk("t2_count", 32'(fetch_count), 32'd2);

        // 3: branch in WAIT discards the read at PC=2
        inc0 = incCnt;
        tick(); branch_en = 1'b1; branch_addr = 12'h3F0;
        neg();
        chk("t3_wrEn", 32'(pc_wrEn), 32'd1);
        chk("t3_dataIn", 32'(pc_dataIn), 32'h3F0);
        chk("t3_no_inc", 32'(pc_incEn), 32'd0);
        tick(); branch_en = 1'b0; expQ.push_back(memArr[12'h3F0]);
        neg();
        chk("t3_no_valid", 32'(instr_valid), 32'd0);
        chk("t3_req_rdEn", 32'(mem_rdEn), 32'd1);
        chk("t3_req_addr", 32'(mem_addr), 32'h3F0);
        chk("t3_inc_suppr", 32'(incCnt - inc0), 32'd0);
        tick();
        // branch together with accept: accepted word still counts
        tick(); branch_en = 1'b1; branch_addr = 12'h100; expQ.push_back(memArr[12'h100]);
        neg();
        chk("t3b_valid", 32'(instr_valid), 32'd1);
        chk("t3b_wrEn", 32'(pc_wrEn), 32'd1);
        tick(); branch_en = 1'b0;
        neg();
        chk("t3b_req_addr", 32'(mem_addr), 32'h100);
        chk("t3b_count", 32'(fetch_count), 32'd3);
        chk("t3b_valid_clr", 32'(instr_valid), 32'd0);
        tick();
        // 4: branch + halt + accept -> redirect, count, IDLE
        tick(); halt = 1'b1; branch_en = 1'b1; branch_addr = 12'h200;
        tick(); halt = 1'b0; branch_en = 1'b0;
        neg();
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_count", 32'(fetch_count), 32'd4);
        chk("t4_valid", 32'(instr_valid), 32'd0);
        chk("t4_pc", 32'(mem_addr), 32'h200);
        rd0 = rdCnt;
        repeat (4) tick();
        neg();
        chk("t4_no_rd", 32'(rdCnt - rd0), 32'd0);
        chk("t4_still_idle", 32'(busy), 32'd0);

        // 6: reset asserted during WAIT
        tick(); start = 1'b1;
        tick(); start = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_valid", 32'(instr_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_rdEn", 32'(mem_rdEn), 32'd0);
        chk("t6_incEn", 32'(pc_incEn), 32'd0);
        chk("t6_count", 32'(fetch_count), 32'd0);
        chk("t6_instr", 32'(instr), 32'd0);
        expQ.delete();
        tick(); rst = 1'b1;
        v0 = validCnt;
        repeat (5) tick();
        neg();
        chk("t6_no_valid", 32'(validCnt - v0), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);

        // 5: 17 back-to-back accepts wrap a 4-bit counter to 1
        for (int i = 0; i < 17; i++) expQ.push_back(memArr[i]);
        a0 = accCnt;
        done = 1'b0;
        tick(); start = 1'b1; instr_ready = 1'b1; halt = 1'b0;
        tick(); start = 1'b0;
        for (int c = 0; c < 120 && !done; c++) begin
            tick();
            if (!busy && (accCnt - a0) == 17) done = 1'b1;
            else if (instr_valid && (accCnt - a0) == 16) halt = 1'b1;
        end
        halt = 1'b0;
        chk("t5_done", 32'(done), 32'd1);
        neg();
        chk("t5_accepts", 32'(accCnt - a0), 32'd17);
        chk("t5_wrap_count", 32'(fetch_count), 32'd1);
        chk("t5_sb_empty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
